// File: rtl/ds_pkg.sv
// Shared definitions for the sinc2 delta-sigma decimator: default ratio,
// output-width rule and the output-state enum.
package ds_pkg;

    localparam int OSR_DEFAULT = 64;

    // Output width: W bits hold 0..OSR^2 exactly (OSR=64 gives W=13).
    function automatic int calc_w(input int osr);
        return 2 * $clog2(osr) + 1;
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ds_decimator_if.sv
// Bitstream input and decimated-sample output bundle for ds_decimator.
interface ds_decimator_if
    import ds_pkg::*;
#(
    parameter int W = calc_w(OSR_DEFAULT)
);

    logic         BIT_IN;
    logic         BIT_EN;
    logic         READY;
    logic [W-1:0] DATA;
    logic         VALID;
    logic         OVERRUN;

    // master drives the bitstream and consumes samples; slave is the decimator.
    modport master (
        output BIT_IN, BIT_EN, READY,
        input  DATA, VALID, OVERRUN
    );

    modport slave (
        input  BIT_IN, BIT_EN, READY,
        output DATA, VALID, OVERRUN
    );

endinterface

// File: rtl/ds_integrator.sv
// W-bit enabled accumulator with synchronous reset; wraps modulo 2^W.
module ds_integrator
    import ds_pkg::*;
#(
    parameter int W = calc_w(OSR_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + in_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ds_decimator.sv
// Sinc2 (second-order CIC) decimator: two bit-rate integrators, decimate by
// OSR, two sample-rate combs, and a valid/ready output register with overrun.
module ds_decimator
    import ds_pkg::*;
#(
    parameter int OSR = OSR_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    ds_decimator_if.slave bus
);

    localparam int W  = calc_w(OSR);
    localparam int CW = $clog2(OSR);

    logic [W-1:0]  bit_ext;
    logic [W-1:0]  int1_q;
    logic [W-1:0]  int2_q;

    logic [CW-1:0] cnt_q,     cnt_d;
    logic [W-1:0]  z1_q,      z1_d;
    logic [W-1:0]  z2_q,      z2_d;
    logic [W-1:0]  data_q,    data_d;
    logic          valid_q,   valid_d;
    logic          overrun_q, overrun_d;
    state_e        state_q,   state_d;

    logic          frame_end;
    logic          load;
    logic          xfer;
    logic [W-1:0]  samp;
    logic [W-1:0]  comb1;
    logic [W-1:0]  comb2;

    assign bit_ext = {{(W-1){1'b0}}, bus.BIT_IN};

    ds_integrator #(.W(W)) u_int1 (
        .clk   (CLK),
        .rst   (RST),
        .en_i  (bus.BIT_EN),
        .in_i  (bit_ext),
        .acc_o (int1_q)
    );

    ds_integrator #(.W(W)) u_int2 (
        .clk   (CLK),
        .rst   (RST),
        .en_i  (bus.BIT_EN),
        .in_i  (int1_q),
        .acc_o (int2_q)
    );

    // Sample the second integrator's post-update value, then comb twice.
    assign samp      = int2_q + int1_q;
    assign comb1     = samp - z1_q;
    assign comb2     = comb1 - z2_q;
    assign frame_end = bus.BIT_EN && (cnt_q == CW'(OSR - 1));
    assign xfer      = valid_q && bus.READY;
    assign load      = frame_end && (state_q == RUN);

    always_comb begin
        cnt_d     = cnt_q;
        z1_d      = z1_q;
        z2_d      = z2_q;
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (bus.BIT_EN) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (frame_end) begin
            z1_d    = samp;
            z2_d    = comb1;
            state_d = RUN;
        end

        // The first frame only primes the combs; its result is dropped.
        if (load) begin
            data_d    = comb2;
            valid_d   = 1'b1;
            overrun_d = valid_q && !bus.READY;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            z1_q      <= '0;
            z2_q      <= '0;
            state_q   <= FILL;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            z1_q      <= z1_d;
            z2_q      <= z2_d;
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.DATA    = data_q;
    assign bus.VALID   = valid_q;
    assign bus.OVERRUN = overrun_q;

endmodule

// File: doc/ds_decimator.md
DS_DECIMATOR -- requirements
Module: ds_decimator

Interface
REQ-001 Parameter OSR, default 64, decimation ratio; SHALL be a power of two, 4..256.
REQ-002 Derived constant W = 2*log2(OSR)+1, output width; holds 0..OSR^2 exactly (OSR=64 gives W=13).
REQ-003 CLK  input  1  single clock; all logic rising-edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 BIT_IN  input  1  delta-sigma bitstream from the modulator DRIVE output.
REQ-006 BIT_EN  input  1  bit strobe; BIT_IN is sampled only on cycles with BIT_EN=1.
REQ-007 DATA  output  W  decimated sample, unsigned; 0 = all zeros, OSR^2 = all ones.
REQ-008 VALID  output  1  DATA holds an unconsumed sample.
REQ-009 READY  input  1  consumer accepts DATA when VALID=1 and READY=1 (transfer).
REQ-010 OVERRUN  output  1  one-cycle pulse: an unconsumed sample was overwritten.

Function
REQ-011 Filter SHALL be sinc2 (second-order CIC): two cascaded integrators at bit rate, decimate by OSR, two cascaded combs at sample rate.
REQ-012 Integrators SHALL update only on BIT_EN=1, input mapped 0->0, 1->1; BIT_EN=0 cycles SHALL leave all state unchanged.
REQ-013 All integrator and comb arithmetic SHALL be W-bit unsigned, wrapping modulo 2^W; no saturation.
REQ-014 Frame counter SHALL count 0..OSR-1 on BIT_EN, wrapping to 0; the BIT_EN cycle with count=OSR-1 is the frame end.
REQ-015 At each frame end the comb stage SHALL evaluate; the result SHALL appear on DATA with VALID=1 exactly one cycle after the frame-end cycle.
REQ-016 State machine: FILL (after reset) and RUN. In FILL the first frame-end result SHALL be discarded (no VALID) and the state SHALL move to RUN; in RUN every frame-end result SHALL be presented.
REQ-017 VALID SHALL stay 1 and DATA stable until a transfer; on the transfer cycle VALID SHALL fall next cycle unless a new sample is loaded on the same edge.
REQ-018 New sample loaded while VALID=1 and READY=0: DATA SHALL take the new value, VALID stays 1, OVERRUN SHALL pulse 1 for one cycle.
REQ-019 New sample loaded on the same edge as a transfer: the new value SHALL load, VALID stays 1, no OVERRUN.
REQ-020 READY SHALL be ignored while VALID=0; VALID SHALL not depend combinationally on READY.

Reset
REQ-021 On RST=1 at a clock edge: integrators, combs, frame counter = 0; state = FILL; DATA = 0; VALID = 0; OVERRUN = 0.
REQ-022 RST mid-frame or with VALID=1 SHALL drop the pending sample without OVERRUN; the first VALID after reset SHALL require two full frames.
REQ-023 RST SHALL take priority over BIT_EN and READY on the same edge.

Structure
REQ-024 Shared package ds_pkg SHALL hold default OSR, a function computing W from OSR, and the state enum (FILL, RUN).
REQ-025 One sub-module ds_integrator (W-bit enabled accumulator, synchronous reset) SHALL be instantiated twice; combs, counter, FSM and output register stay in ds_decimator.
REQ-026 Target size 120-400 lines RTL; no vendor primitives.

Verification (OSR=64, W=13)
REQ-027 BIT_IN=1, BIT_EN=1 constant, READY=1 -> first VALID after 128 bits, DATA=4096, then 4096 every 64 bits.
REQ-028 BIT_IN=0 constant -> every sample DATA=0; alternating 1/0 -> steady-state DATA within 2048+/-64.
REQ-029 BIT_EN asserted every 3rd cycle, BIT_IN=1 -> identical values (4096) at 1/192-cycle spacing; no state change on idle cycles.
REQ-030 READY=0 across two frame ends -> VALID held, OVERRUN single-cycle pulse at second load, DATA = newest sample; READY=1 then -> one transfer, VALID falls.
REQ-031 Transfer and new load on the same edge -> VALID remains 1, DATA updates, OVERRUN=0.
REQ-032 RST pulsed at bit 30 of a frame while VALID=1 -> VALID=0 next cycle, no OVERRUN, next VALID exactly 128 bits after reset release.
